// File: rtl/nt_monitor_pkg.sv
// Shared state encoding, MISR defaults and counter helper for the Nt-node activity monitor.
package nt_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    OBSERVE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [15:0] DEF_SIG_POLY = 16'h1021;
  localparam logic [15:0] DEF_SIG_SEED = 16'hFFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/nt_node_activity_monitor_if.sv
// Observation/readout bundle between the activity monitor and its stimulus and collection logic.
interface nt_node_activity_monitor_if #(
  parameter int CNT_W = 16,
  parameter int SIG_W = 16
);

  logic             node_in;
  logic             en;
  logic             win_start;
  logic             rd_req;
  logic             rd_ack;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] toggle_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic [SIG_W-1:0] signature;
  logic             rare_flag;

  modport master (
    output node_in, en, win_start, rd_req,
    input  rd_ack, busy, done, toggle_cnt, low_cnt, signature, rare_flag
  );

  modport slave (
    input  node_in, en, win_start, rd_req,
    output rd_ack, busy, done, toggle_cnt, low_cnt, signature, rare_flag
  );

endinterface

// File: rtl/nt_misr.sv
// Serial-input MISR compacting one sampled bit per enabled cycle; result visible one cycle after the shift.
// load wins over shift_en; no backpressure, the caller gates shift_en.
module nt_misr
  import nt_monitor_pkg::*;
#(
  parameter int             SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(DEF_SIG_POLY),
  parameter logic [SIG_W-1:0] SIG_SEED = SIG_W'(DEF_SIG_SEED)
) (
  input  logic             core_clk,
  input  logic             arst_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] feedback;
  logic [SIG_W-1:0] sig_next;

  always_comb begin
    feedback = sig[SIG_W-1] ? SIG_POLY : '0;
    sig_next = {sig[SIG_W-2:0], 1'b0} ^ feedback ^ {{(SIG_W-1){1'b0}}, din};
  end

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      sig <= '0;
    end else if (load) begin
      sig <= SIG_SEED;
    end else if (shift_en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/nt_node_activity_monitor.sv
// Windowed toggle/low counter and MISR on one Nt-node output; done 2+WINDOW cycles after win_start (+1 per en=0 cycle).
// en=0 pauses the window; results held until rd_req, acknowledged by a one-cycle rd_ack.
module nt_node_activity_monitor
  import nt_monitor_pkg::*;
#(
  parameter int               WINDOW      = 256,
  parameter int               CNT_W       = 16,
  parameter int               SIG_W       = 16,
  parameter logic [SIG_W-1:0] SIG_POLY    = SIG_W'(DEF_SIG_POLY),
  parameter logic [SIG_W-1:0] SIG_SEED    = SIG_W'(DEF_SIG_SEED),
  parameter int               RARE_THRESH = 4
) (
  input  logic                        I1294,
  input  logic                        I1301,
  nt_node_activity_monitor_if.slave   mon
);

  localparam int               WIN_W   = $clog2(WINDOW + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q;
  state_t           state_d;
  logic             node_q;
  logic             node_qq;
  logic [WIN_W-1:0] win_q;
  logic [CNT_W-1:0] toggle_q;
  logic [CNT_W-1:0] low_q;
  logic [SIG_W-1:0] sig;
  logic             busy_q;
  logic             done_q;
  logic             rd_ack_q;
  logic             sample;
  logic             win_last;

  // Two-stage input capture runs in every state so the first sample has a real predecessor.
  always_ff @(posedge I1294 or negedge I1301) begin
    if (!I1301) begin
      node_q  <= 1'b0;
      node_qq <= 1'b0;
    end else begin
      node_q  <= mon.node_in;
      node_qq <= node_q;
    end
  end

  assign sample   = (state_q == OBSERVE) && mon.en;
  assign win_last = (win_q == WIN_W'(WINDOW - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mon.win_start)       state_d = ARM;
      ARM:                              state_d = OBSERVE;
      OBSERVE: if (sample && win_last)  state_d = HOLD;
      HOLD:    if (mon.rd_req)          state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  always_ff @(posedge I1294 or negedge I1301) begin
    if (!I1301) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= (state_d == ARM) || (state_d == OBSERVE);
      done_q   <= (state_d == HOLD);
      rd_ack_q <= (state_q == HOLD) && mon.rd_req;
    end
  end

  always_ff @(posedge I1294 or negedge I1301) begin
    if (!I1301) begin
      win_q    <= '0;
      toggle_q <= '0;
      low_q    <= '0;
    end else if (state_q == ARM) begin
      win_q    <= '0;
      toggle_q <= '0;
      low_q    <= '0;
    end else if (sample) begin
      win_q <= win_q + WIN_W'(1);
      if (node_q != node_qq) begin
        toggle_q <= CNT_W'(sat_inc(32'(toggle_q), 32'(CNT_MAX)));
      end
      if (!node_q) begin
        low_q <= CNT_W'(sat_inc(32'(low_q), 32'(CNT_MAX)));
      end
    end
  end

  nt_misr #(
    .SIG_W    (SIG_W),
    .SIG_POLY (SIG_POLY),
    .SIG_SEED (SIG_SEED)
  ) u_misr (
    .core_clk (I1294),
    .arst_n   (I1301),
    .load     (state_q == ARM),
    .shift_en (sample),
    .din      (node_q),
    .sig      (sig)
  );

  assign mon.busy       = busy_q;
  assign mon.done       = done_q;
  assign mon.rd_ack     = rd_ack_q;
  assign mon.toggle_cnt = toggle_q;
  assign mon.low_cnt    = low_q;
  assign mon.signature  = sig;
  assign mon.rare_flag  = done_q && (32'(low_q) < 32'(RARE_THRESH));

endmodule

// File: tb/tb_nt_node_activity_monitor.sv
// Scoreboard bench: stimulus queues hand-computed window results, per-DUT monitors check them when done rises.
module tb_nt_node_activity_monitor;

  typedef struct {
    int          cyc;
    logic [31:0] tog;
    logic [31:0] low;
    logic [31:0] sig;
    logic        rare;
    bit          chk_sig;
  } exp_t;

  logic clk;
  logic rst_n;
  logic node_in;
  logic en;
  logic start_a, start_b, start_c;
  logic rd_req_a;
  int   cyc;
  int   n_chk;
  int   n_err;
  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  logic pa, pb, pc;

  nt_node_activity_monitor_if #(.CNT_W(16), .SIG_W(16)) ifa ();
  nt_node_activity_monitor_if #(.CNT_W(16), .SIG_W(16)) ifb ();
  nt_node_activity_monitor_if #(.CNT_W(3),  .SIG_W(16)) ifc ();

  assign ifa.node_in = node_in;
  assign ifa.en = en;
  assign ifa.win_start = start_a;
  assign ifa.rd_req = rd_req_a;
  assign ifb.node_in = node_in;
  assign ifb.en = en;
  assign ifb.win_start = start_b;
  assign ifb.rd_req = 1'b0;
  assign ifc.node_in = node_in;
  assign ifc.en = en;
  assign ifc.win_start = start_c;
  assign ifc.rd_req = 1'b0;

  nt_node_activity_monitor #(
    .WINDOW(8), .CNT_W(16), .SIG_W(16), .SIG_POLY(16'h1021), .SIG_SEED(16'hFFFF), .RARE_THRESH(4)
  ) dut_a (.I1294(clk), .I1301(rst_n), .mon(ifa));

  nt_node_activity_monitor #(
    .WINDOW(4), .CNT_W(16), .SIG_W(16), .SIG_POLY(16'h1021), .SIG_SEED(16'h0001), .RARE_THRESH(4)
  ) dut_b (.I1294(clk), .I1301(rst_n), .mon(ifb));

  nt_node_activity_monitor #(
    .WINDOW(12), .CNT_W(3), .SIG_W(16), .SIG_POLY(16'h1021), .SIG_SEED(16'hFFFF), .RARE_THRESH(4)
  ) dut_c (.I1294(clk), .I1301(rst_n), .mon(ifc));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [31:0] tog, input logic [31:0] low,
                     input logic [31:0] sig, input logic rare);
    chk({tag, "_done_cycle"}, cyc, e.cyc);
    chk({tag, "_toggle_cnt"}, tog, e.tog);
    chk({tag, "_low_cnt"}, low, e.low);
    chk({tag, "_rare_flag"}, {31'd0, rare}, {31'd0, e.rare});
    if (e.chk_sig) chk({tag, "_signature"}, sig, e.sig);
  endtask

  task automatic unexpected(input string tag);
    n_chk++;
    n_err++;
    $display("FAIL %s_unexpected_done: got done=1 required no pending result (cycle %0d)", tag, cyc);
  endtask

  // Monitors: one result per rising edge of done.
  initial begin
    pa = 1'b0; pb = 1'b0; pc = 1'b0;
  end

  always @(negedge clk) begin
    if (ifa.done && !pa) begin
      if (qa.size() == 0) unexpected("A");
      else cmp("A", qa.pop_front(), 32'(ifa.toggle_cnt), 32'(ifa.low_cnt), 32'(ifa.signature), ifa.rare_flag);
    end
    if (ifb.done && !pb) begin
      if (qb.size() == 0) unexpected("B");
      else cmp("B", qb.pop_front(), 32'(ifb.toggle_cnt), 32'(ifb.low_cnt), 32'(ifb.signature), ifb.rare_flag);
    end
    if (ifc.done && !pc) begin
      if (qc.size() == 0) unexpected("C");
      else cmp("C", qc.pop_front(), 32'(ifc.toggle_cnt), 32'(ifc.low_cnt), 32'(ifc.signature), ifc.rare_flag);
    end
    pa = ifa.done;
    pb = ifb.done;
    pc = ifc.done;
  end

  // Constant-1 window on A: no toggles, no lows, rare, known MISR value.
  task automatic run_const_one_a();
    node_in = 1'b1;
    repeat (2) @(negedge clk);
    start_a = 1'b1;
    qa.push_back('{cyc: cyc + 10, tog: 32'd0, low: 32'd0, sig: 32'h0000E10F, rare: 1'b1, chk_sig: 1'b1});
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic readout_a(input bit with_start, input logic [31:0] exp_low);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (ifa.done) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      chk("A_wait_done_timeout", 32'd0, 32'd1);
    end else begin
      rd_req_a = 1'b1;
      start_a  = with_start;
      @(negedge clk);
      rd_req_a = 1'b0;
      start_a  = 1'b0;
      chk("A_rd_ack_pulse", {31'd0, ifa.rd_ack}, 32'd1);
      chk("A_done_after_rd", {31'd0, ifa.done}, 32'd0);
      chk("A_busy_after_rd", {31'd0, ifa.busy}, 32'd0);
      chk("A_rare_in_idle", {31'd0, ifa.rare_flag}, 32'd0);
      chk("A_low_retained", 32'(ifa.low_cnt), exp_low);
      @(negedge clk);
      chk("A_rd_ack_one_cycle", {31'd0, ifa.rd_ack}, 32'd0);
      chk("A_busy_stays_idle", {31'd0, ifa.busy}, 32'd0);
    end
  endtask

  // Alternating node (pre-window 1, first sample 0), optional en=0 pause.
  task automatic run_alt_a(input int pause_len);
    for (int i = 0; i <= 14 + pause_len; i++) begin
      node_in = (i % 2 == 0);
      start_a = (i == 0) || (i == 5 && pause_len == 0);
      en = !(pause_len > 0 && i >= 4 && i < 4 + pause_len);
      if (i == 0)
        qa.push_back('{cyc: cyc + 10 + pause_len, tog: 32'd8, low: 32'd4, sig: 32'd0, rare: 1'b0, chk_sig: 1'b0});
      @(negedge clk);
    end
    start_a = 1'b0;
    en = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    node_in = 1'b0;
    en = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    rd_req_a = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, ifa.busy}, 32'd0);
    chk("reset_done", {31'd0, ifa.done}, 32'd0);
    chk("reset_rd_ack", {31'd0, ifa.rd_ack}, 32'd0);
    chk("reset_toggle", 32'(ifa.toggle_cnt), 32'd0);
    chk("reset_low", 32'(ifa.low_cnt), 32'd0);
    chk("reset_signature", 32'(ifa.signature), 32'd0);
    chk("reset_rare", {31'd0, ifa.rare_flag}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_const_one_a();
    readout_a(1'b0, 32'd0);

    run_alt_a(0);
    readout_a(1'b0, 32'd4);

    run_alt_a(3);
    readout_a(1'b0, 32'd4);

    // Reset in the middle of a run with node low: partial counts must vanish.
    node_in = 1'b0;
    repeat (2) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy_before_rst", {31'd0, ifa.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, ifa.busy}, 32'd0);
    chk("mid_rst_low", 32'(ifa.low_cnt), 32'd0);
    chk("mid_rst_signature", 32'(ifa.signature), 32'd0);
    chk("mid_rst_done", {31'd0, ifa.done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_const_one_a();
    readout_a(1'b1, 32'd0);
    run_const_one_a();
    readout_a(1'b0, 32'd0);

    node_in = 1'b0;
    repeat (2) @(negedge clk);
    start_b = 1'b1;
    start_c = 1'b1;
    qb.push_back('{cyc: cyc + 6, tog: 32'd0, low: 32'd4, sig: 32'h00000010, rare: 1'b0, chk_sig: 1'b1});
    qc.push_back('{cyc: cyc + 14, tog: 32'd0, low: 32'd7, sig: 32'd0, rare: 1'b0, chk_sig: 1'b0});
    @(negedge clk);
    start_b = 1'b0;
    start_c = 1'b0;

    for (int i = 0; i < 100 && (qa.size() + qb.size() + qc.size()) != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    while (qa.size() != 0) begin void'(qa.pop_front()); chk("A_result_never_seen", 32'd0, 32'd1); end
    while (qb.size() != 0) begin void'(qb.pop_front()); chk("B_result_never_seen", 32'd0, 32'd1); end
    while (qc.size() != 0) begin void'(qc.pop_front()); chk("C_result_never_seen", 32'd0, 32'd1); end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nt_node_activity_monitor.md
# nt_node_activity_monitor

Observation stage placed directly downstream of an Nt-node subcircuit. It consumes that subcircuit's single-bit output net for a programmable window of cycles, then counts toggles and low-level occurrences and compacts the sampled stream into a MISR signature. It raises a rare-activation flag when the node was almost never driven low, and hands the result to the collection logic through a request/acknowledge readout.

## Interface
- WINDOW, 256: observation cycles per run (≥2)
- CNT_W, 16: width of the toggle and low-level counters
- SIG_W, 16: MISR width
- SIG_POLY, 16'h1021: MISR feedback polynomial
- SIG_SEED, 16'hFFFF: MISR value loaded at arm
- RARE_THRESH, 4: rare_flag asserts when low_cnt < RARE_THRESH
- I1294  in  1  clock; all flops rise-edge
- I1301  in  1  reset, asynchronous, active-low
- node_in  in  1  observed subcircuit output net
- en  in  1  observation enable; low pauses an active window
- win_start  in  1  single-cycle pulse; honoured only in IDLE
- rd_req  in  1  readout request; honoured only in HOLD
- rd_ack  out  1  single-cycle acknowledge
- busy  out  1  high in ARM and OBSERVE
- done  out  1  high in HOLD
- toggle_cnt  out  CNT_W  saturating count of sampled transitions
- low_cnt  out  CNT_W  saturating count of samples equal to 0
- signature  out  SIG_W  MISR state
- rare_flag  out  1  valid while done=1, otherwise 0

## Operation
- Input stage: node_q <= node_in and node_qq <= node_q run every cycle, in every state.
- States:
  - IDLE: win_start=1 moves to ARM.
  - ARM: one cycle; clears the counters and window counter and loads signature=SIG_SEED; then OBSERVE.
  - OBSERVE: each cycle with en=1 processes the sample node_q and increments the window counter. When the window counter reaches WINDOW, moves to HOLD. Cycles with en=0 freeze all statistics and the window counter.
  - HOLD: results are stable. rd_req=1 pulses rd_ack on the next cycle and returns to IDLE.
- Per sample:
  - toggle_cnt+1 if node_q≠node_qq. The first sample compares against the pre-window value.
  - low_cnt+1 if node_q=0.
  - Both counters saturate at 2^CNT_W−1.
- MISR update: sig_next = (sig<<1) ^ (sig[SIG_W−1] ? SIG_POLY : 0) ^ {0…,node_q}.
- rare_flag = done & (low_cnt < RARE_THRESH).
- Results remain readable in IDLE until the next ARM clears them.
- win_start outside IDLE is ignored. rd_req outside HOLD is ignored.
- rd_req and win_start in the same HOLD cycle: the readout completes and win_start is dropped.

## Timing
- Reset (I1301=0) acts immediately. It forces IDLE and sets every output to 0, including signature, toggle_cnt and low_cnt. node_q and node_qq reset to 0.
- Reset mid-OBSERVE discards the run. No partial results are kept.
- With en held high: win_start at cycle t gives ARM at t+1, OBSERVE from t+2 to t+1+WINDOW, and HOLD with done=1 from t+2+WINDOW.
- Each en=0 cycle extends the window by one cycle.
- Sampling latency: the sample processed in cycle c is node_in at c−1.
- rd_req in HOLD at cycle h gives rd_ack=1 and state IDLE at h+1. done falls at h+1. rd_ack is high for exactly one cycle.
- Outputs are registered, except rare_flag, which is a single compare on registered values.

## Structure
- Package nt_monitor_pkg:
  - state enum {IDLE, ARM, OBSERVE, HOLD}
  - default SIG_POLY and SIG_SEED constants
  - saturating-increment function
- Sub-module nt_misr: parameters SIG_W, SIG_POLY and SIG_SEED; ports load, shift_en and din; output sig.
- The top level holds the input registers, the FSM, the window counter and the two counters.

## Test plan
- WINDOW=8, node_in held at 1, en=1, win_start pulse: done rises 10 cycles later. toggle_cnt=0, low_cnt=0, rare_flag=1.
- WINDOW=8, node_in alternating 0/1 (pre-window sample 1, first sample 0): toggle_cnt=8, low_cnt=4, rare_flag=0.
- WINDOW=4, SIG_SEED=16'h0001, node_in held at 0: signature after the window is 16'h0010.
- CNT_W=3, WINDOW=12, node_in held at 0: low_cnt saturates at 7.
- en low for 3 cycles mid-window: done is delayed by exactly 3 cycles and the counts are unchanged versus the en=1 run. Reset asserted mid-OBSERVE: all outputs are 0 immediately, and a subsequent run produces correct results.
- In HOLD, rd_req together with win_start: rd_ack for one cycle, then IDLE, and no new run starts. A later win_start is accepted. win_start during OBSERVE has no effect.
